// File: rtl/int_to_float.sv
// int_to_float: iterative 32-bit integer to IEEE-754 single conversion with valid/ready handshakes.
// Define INT2FP_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated toward zero.
module int_to_float #(
  parameter int SIGNED     = 1,
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        inexact,
  output logic        busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]            state_q, state_d;
  logic                  sign_q, sign_d;
  logic [31:0]           mag_q, mag_d;
  logic [7:0]            exp_q, exp_d;
  logic [31:0]           result_q, result_d;
  logic                  inexact_q, inexact_d;
  logic                  neg;
  logic [SHIFT_STEP-1:0] top;
  logic [4:0]            lz;
  logic [22:0]           mant;
  logic                  grd, sticky, up;
  logic [23:0]           mant_sum;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign result    = result_q;
  assign inexact   = inexact_q;
  assign neg       = (SIGNED != 0) && data_in[31];
  assign top       = mag_q[31 -: SHIFT_STEP];
  assign mant      = mag_q[30:8];
  assign grd       = mag_q[7];
  assign sticky    = |mag_q[6:0];
`ifdef INT2FP_ROUND_EN
  assign up        = grd & (sticky | mant[0]);
`else
  assign up        = 1'b0;
`endif
  // a carry out of the mantissa bumps the exponent and leaves the mantissa at zero
  assign mant_sum  = {1'b0, mant} + {23'd0, up};
  // leading-zero count of the top window; the highest set bit wins
  always_comb begin
    lz = '0;
    for (int i = 0; i < SHIFT_STEP; i++)
      if (top[i]) lz = 5'(SHIFT_STEP - 1 - i);
  end
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    result_d  = result_q;
    inexact_d = inexact_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d    = neg;
        mag_d     = neg ? -data_in : data_in;
        exp_d     = 8'd158;
        result_d  = '0;
        inexact_d = 1'b0;
        state_d   = (data_in == '0) ? DONE : NORM;
      end
      NORM: begin
        mag_d   = (top == '0) ? mag_q << SHIFT_STEP : mag_q << lz;
        exp_d   = exp_q - ((top == '0) ? 8'(SHIFT_STEP) : {3'd0, lz});
        state_d = (top == '0) ? NORM : ROUND;
      end
      ROUND: begin
        result_d  = {sign_q, exp_q + {7'd0, mant_sum[23]}, mant_sum[22:0]};
        inexact_d = grd | sticky;
        state_d   = DONE;
      end
      default: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      result_q  <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      result_q  <= result_d;
      inexact_q <= inexact_d;
    end
endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: randomized and directed conversions checked against a double-precision based reference.
module tb_int_to_float;
  localparam int S = 8;
`ifdef INT2FP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        inexact;
  logic        busy;
  int          total = 0;
  int          bad = 0;

  int_to_float #(.SIGNED(1), .SHIFT_STEP(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .inexact(inexact), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // integers are exact in double; rounding the double down to single gives the expected float
  function automatic void ref_model(input logic [31:0] d, output logic [31:0] r, output logic inx, output int lat);
    logic [63:0] b;
    int          e;
    logic        g, s, up;
    if (d == '0) begin
      r = '0; inx = 1'b0; lat = 1;
      return;
    end
    b   = $realtobits($itor($signed(d)));
    e   = int'(b[62:52]) - 1023;
    g   = b[28];
    s   = |b[27:0];
    up  = RND && g && (s || b[29]);
    r   = {b[63], 8'(e + 127), b[51:29]} + {31'd0, up};
    inx = g | s;
    lat = (31 - e) / S + 3;
  endfunction

  task automatic convert(input logic [31:0] d, input int hold);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          n;
    ref_model(d, er, ei, el);
    @(posedge clk); #1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = $urandom;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, el);
    chk("result", result, er);
    chk("inexact", {31'd0, inexact}, {31'd0, ei});
    chk("busy_done", {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, er);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    convert(32'h0000_0001, 0);
    chk("t1_value", result, 32'h3F80_0000);
    convert(32'hFFFF_FFFF, 1);
    convert(32'h8000_0000, 0);
    convert(32'h0000_0000, 2);
    convert(32'h0100_0003, 0);
    convert(32'h7FFF_FFFF, 0);
    convert(32'h0000_0100, 0);
    convert(32'h1234_5678, 5);
    // abort mid-normalisation; the next operand must convert cleanly
    @(posedge clk); #1;
    in_valid = 1'b1;
    data_in  = 32'h0000_0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("norm_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    convert(32'h0000_0003, 1);
    for (int k = 0; k < 60; k++) begin
      logic [31:0] v;
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      convert(v, $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
